// File: rtl/wbh_sched_pkg.sv
// wbh_sched_pkg: shared FSM states, clock-control decode constants and helpers
// for the register-bus scheduler (wbh_reg_sched) and its arbiter (wbh_rr_arb3).
package wbh_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_GATE_PRE,
      ST_CLK_WR,
      ST_GATE_POST,
      ST_DONE
   } sched_state_e;

   localparam logic [2:0]  CLK_CTRL_ADDR   = 3'd0;
   localparam int          CLK_CTRL_BE_BIT = 2;
   localparam logic [31:0] TMO_RDATA       = 32'hDEAD_BEEF;

   function automatic logic [1:0] oh2idx(input logic [2:0] oh);
      return oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
   endfunction

endpackage

// File: rtl/wbh_rr_arb3.sv
// wbh_rr_arb3: 3-way round-robin arbiter with one-hot grant.
// Ports: mclk/s_reset (sync active-high), req[2:0] requests, accept (commit the
// current grant and advance priority), grant[2:0] one-hot winner.
// Priority starts just after the last accepted grant; reset treats 2 as last.
module wbh_rr_arb3
   import wbh_sched_pkg::*;
(
   input  logic       mclk,
   input  logic       s_reset,
   input  logic [2:0] req,
   input  logic       accept,
   output logic [2:0] grant
);

   logic [1:0] last;

   // Walk from lowest to highest priority so the highest-priority hit wins.
   always_comb begin
      grant = '0;
      for (int k = 2; k >= 0; k--)
         if (req[(int'(last) + 1 + k) % 3]) grant = 3'(1) << ((int'(last) + 1 + k) % 3);
   end

   always_ff @(posedge mclk)
      if (s_reset) last <= 2'd2;
      else if (accept && |grant) last <= oh2idx(grant);

endmodule

// File: rtl/wbh_reg_sched.sv
// wbh_reg_sched: serialises three requesters onto one register bus and wraps
// clock-control writes in a clock-gate window (clk_enb low before/after).
// Ports: mclk, s_reset (sync active-high); req_* requester side (0 host,
// 1 uart master, 2 strap/boot FSM); reg_* register bus; clk_enb, sched_busy,
// tmo_err status.
// Build option: WBH_SCHED_TMO_EN enables the ack timeout (TMO_CYC cycles);
// without it the bus waits forever and tmo_err stays 0.
module wbh_reg_sched
   import wbh_sched_pkg::*;
#(
   parameter int GATE_PRE  = 4,
   parameter int GATE_POST = 8,
   parameter int TMO_CYC   = 64
) (
   input  logic        mclk,
   input  logic        s_reset,
   input  logic [2:0]  req_cs,
   input  logic [2:0]  req_wr,
   input  logic [8:0]  req_addr,
   input  logic [95:0] req_wdata,
   input  logic [11:0] req_be,
   output logic [2:0]  req_ack,
   output logic [31:0] req_rdata,
   output logic        reg_cs,
   output logic        reg_wr,
   output logic [2:0]  reg_addr,
   output logic [31:0] reg_wdata,
   output logic [3:0]  reg_be,
   input  logic [31:0] reg_rdata,
   input  logic        reg_ack,
   output logic        clk_enb,
   output logic        sched_busy,
   output logic        tmo_err
);

`ifdef WBH_SCHED_TMO_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int GMAX = GATE_PRE > GATE_POST ? GATE_PRE : GATE_POST;
   localparam int GW   = GMAX > 1 ? $clog2(GMAX) : 1;
   localparam int TW   = $clog2(TMO_CYC + 1);

   sched_state_e state, state_n;
   logic [2:0]  gnt, gnt_q;
   logic [1:0]  gidx;
   logic        sel_wr, clk_sw, gdone, ack_ok, tmo_hit, upd_q, tmo_q;
   logic [2:0]  sel_addr;
   logic [3:0]  sel_be;
   logic [GW-1:0] gcnt;
   logic [TW-1:0] tcnt;
   logic [31:0] cap_q;

   // The requester being acked this cycle is masked so a still-high req_cs
   // is not mistaken for a fresh request.
   wbh_rr_arb3 u_arb (
      .mclk    (mclk),
      .s_reset (s_reset),
      .req     (req_cs & ~req_ack),
      .accept  (state == ST_IDLE),
      .grant   (gnt)
   );

   assign gidx     = oh2idx(gnt);
   assign sel_wr   = req_wr[gidx];
   assign sel_addr = req_addr[gidx*3 +: 3];
   assign sel_be   = req_be[gidx*4 +: 4];
   assign clk_sw   = sel_wr && sel_addr == CLK_CTRL_ADDR && sel_be[CLK_CTRL_BE_BIT];
   assign gdone    = gcnt == '0;
   assign ack_ok   = reg_cs && reg_ack;
   assign tmo_hit  = TMO_EN && reg_cs && !reg_ack && tcnt == TW'(TMO_CYC - 1);

   assign clk_enb    = !(state inside {ST_GATE_PRE, ST_CLK_WR, ST_GATE_POST});
   assign sched_busy = state != ST_IDLE;
   assign tmo_err    = tmo_q;

   always_ff @(posedge mclk)
      if (s_reset) state <= ST_IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:      if (|gnt) state_n = !clk_sw ? ST_ISSUE : GATE_PRE == 0 ? ST_CLK_WR : ST_GATE_PRE;
         ST_ISSUE:     state_n = ST_WAIT_ACK;
         ST_WAIT_ACK:  if (ack_ok || tmo_hit) state_n = ST_DONE;
         ST_GATE_PRE:  if (gdone) state_n = ST_CLK_WR;
         ST_CLK_WR:    if (ack_ok || tmo_hit) state_n = GATE_POST == 0 ? ST_DONE : ST_GATE_POST;
         ST_GATE_POST: if (gdone) state_n = ST_DONE;
         ST_DONE:      state_n = ST_IDLE;
         default:      state_n = ST_IDLE;
      endcase
   end

   // reg_cs is registered from the next state: high exactly in WAIT_ACK and
   // CLK_WR, and it falls on the edge that samples the ack.
   always_ff @(posedge mclk)
      if (s_reset) begin
         gnt_q     <= '0;
         reg_wr    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_be    <= '0;
         reg_cs    <= 1'b0;
         gcnt      <= '0;
         cap_q     <= '0;
         upd_q     <= 1'b0;
         req_ack   <= '0;
         req_rdata <= '0;
      end else begin
         req_ack <= '0;
         reg_cs  <= state_n == ST_WAIT_ACK || state_n == ST_CLK_WR;
         if (state == ST_IDLE && |gnt) begin
            gnt_q     <= gnt;
            reg_wr    <= sel_wr;
            reg_addr  <= sel_addr;
            reg_wdata <= req_wdata[gidx*32 +: 32];
            reg_be    <= sel_be;
            gcnt      <= GW'(GATE_PRE - 1);
         end
         if ((state == ST_GATE_PRE || state == ST_GATE_POST) && !gdone) gcnt <= gcnt - GW'(1);
         if (ack_ok || tmo_hit) begin
            cap_q <= ack_ok ? reg_rdata : TMO_RDATA;
            upd_q <= !reg_wr || !ack_ok;
            gcnt  <= GW'(GATE_POST - 1);
         end
         if (state == ST_DONE) begin
            req_ack <= gnt_q;
            if (upd_q) req_rdata <= cap_q;
         end
      end

   // Counts cycles with reg_cs high; only acts when the timeout is built in.
   always_ff @(posedge mclk)
      if (s_reset) begin
         tcnt  <= '0;
         tmo_q <= 1'b0;
      end else begin
         tcnt <= reg_cs && !tmo_hit ? tcnt + TW'(1) : '0;
         if (tmo_hit) tmo_q <= 1'b1;
      end

endmodule

// File: tb/tb_wbh_reg_sched.sv
// tb_wbh_reg_sched: randomized scoreboard bench for wbh_reg_sched with a
// behavioural register-file slave and a shadow-memory reference model.
module tb_wbh_reg_sched;
   import wbh_sched_pkg::*;

   localparam int GP = 4;
   localparam int GQ = 8;

   logic        mclk = 1'b0;
   logic        s_reset;
   logic [2:0]  req_cs, req_wr, req_ack;
   logic [8:0]  req_addr;
   logic [95:0] req_wdata;
   logic [11:0] req_be;
   logic [31:0] req_rdata, reg_wdata, reg_rdata;
   logic        reg_cs, reg_wr, reg_ack, clk_enb, sched_busy, tmo_err;
   logic [2:0]  reg_addr;
   logic [3:0]  reg_be;

   wbh_reg_sched #(.GATE_PRE(GP), .GATE_POST(GQ), .TMO_CYC(64)) dut (
      .mclk(mclk), .s_reset(s_reset),
      .req_cs(req_cs), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_be(req_be), .req_ack(req_ack), .req_rdata(req_rdata),
      .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .clk_enb(clk_enb), .sched_busy(sched_busy), .tmo_err(tmo_err)
   );

   always #5 mclk = ~mclk;

   // Register-file slave: acks combinationally once reg_cs has been high for lat cycles.
   logic [31:0] smem [8];
   int          hcnt = 0;
   int          lat = 0;
   bit          ack_en = 1'b1;
   assign reg_ack   = reg_cs && ack_en && hcnt >= lat;
   assign reg_rdata = smem[reg_addr];
   always @(posedge mclk) begin
      hcnt <= reg_cs ? hcnt + 1 : 0;
      if (reg_cs && reg_ack && reg_wr)
         for (int b = 0; b < 4; b++) if (reg_be[b]) smem[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
   end

   // Reference model: shadow register file and last returned read data.
   typedef struct { int idx; logic [31:0] rd; } exp_t;
   exp_t        sb[$];
   exp_t        e_m;
   logic [31:0] shadow [8];
   logic [31:0] last_rd;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          prev_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_write(input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
      for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
   endtask

   task automatic expect_txn(input int i, input bit wr, input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
      if (wr) model_write(a, be, wd);
      else last_rd = shadow[a];
      sb.push_back('{i, last_rd});
   endtask

   task automatic drive(input int i, input bit wr, input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
      req_wr[i] = wr;
      req_addr[3*i +: 3] = a;
      req_wdata[32*i +: 32] = wd;
      req_be[4*i +: 4] = be;
      req_cs[i] = 1'b1;
   endtask

   task automatic wait_ack(input int i, input int budget, output int cyc);
      cyc = 0;
      while (cyc < budget && !req_ack[i]) begin
         @(negedge mclk);
         cyc++;
      end
      if (!req_ack[i]) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ack_timeout req%0d: got no ack expected ack within %0d cycles", i, budget);
      end
      req_cs[i] = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every ack and checks the bus gap rule.
   always @(negedge mclk) begin
      if (prev_done) chk("reg_cs_gap", 32'(reg_cs), 32'(0));
      prev_done = reg_cs && reg_ack;
      if (req_ack != 3'b000) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: got %b expected none", req_ack);
         end else begin
            e_m = sb.pop_front();
            chk("ack_idx", 32'(req_ack), 32'(1) << e_m.idx);
            chk("rdata", req_rdata, e_m.rd);
         end
      end
   end

   initial begin
      int i, cyc, lc, pre, post, phase;
      bit wr, ce_drop, cs_ce, ack_ce, seen;
      logic [2:0] a;
      logic [3:0] be;
      logic [31:0] wd;
      logic [2:0] aa [3];
      int rem [3];
      int left [3];
      int lastg, guard;

      req_cs = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_be = '0;
      for (int k = 0; k < 8; k++) begin
         smem[k] = $urandom;
         shadow[k] = smem[k];
      end
      last_rd = '0;
      s_reset = 1'b1;
      repeat (3) @(negedge mclk);
      s_reset = 1'b0;

      chk("rst_reg_cs", 32'(reg_cs), 32'(0));
      chk("rst_reg_wr", 32'(reg_wr), 32'(0));
      chk("rst_reg_addr", 32'(reg_addr), 32'(0));
      chk("rst_reg_wdata", reg_wdata, 32'(0));
      chk("rst_reg_be", 32'(reg_be), 32'(0));
      chk("rst_req_ack", 32'(req_ack), 32'(0));
      chk("rst_req_rdata", req_rdata, 32'(0));
      chk("rst_clk_enb", 32'(clk_enb), 32'(1));
      chk("rst_busy", 32'(sched_busy), 32'(0));
      chk("rst_tmo_err", 32'(tmo_err), 32'(0));

      // Single read from requester 1 with a one-cycle ack.
      lat = 0;
      smem[2] = 32'h1234_5678;
      shadow[2] = 32'h1234_5678;
      expect_txn(1, 1'b0, 3'd2, 4'hF, 32'h0);
      drive(1, 1'b0, 3'd2, 4'hF, 32'h0);
      ce_drop = 1'b0;
      for (lc = 1; lc <= 50; lc++) begin
         @(posedge mclk);
         #1;
         if (!clk_enb) ce_drop = 1'b1;
         if (req_ack[1]) break;
      end
      req_cs[1] = 1'b0;
      chk("read_latency", 32'(lc), 32'(4));
      chk("read_clk_enb_drop", 32'(ce_drop), 32'(0));

      // Clock-control write: gate window before and after the bus write.
      @(negedge mclk);
      expect_txn(0, 1'b1, CLK_CTRL_ADDR, 4'b0100, 32'h0055_0000);
      drive(0, 1'b1, CLK_CTRL_ADDR, 4'b0100, 32'h0055_0000);
      pre = 0; post = 0; phase = 0; cs_ce = 1'b1; ack_ce = 1'b0; seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(posedge mclk);
         #1;
         if (phase == 0) begin
            if (reg_cs && reg_ack) begin
               phase = 1;
               cs_ce = clk_enb;
            end else if (!clk_enb && !reg_cs) pre++;
         end else if (req_ack[0]) begin
            seen = 1'b1;
            ack_ce = clk_enb;
         end else if (!clk_enb) post++;
      end
      req_cs[0] = 1'b0;
      chk("gate_pre_cycles", 32'(pre), 32'(GP));
      chk("gate_post_cycles", 32'(post), 32'(GQ));
      chk("clk_enb_during_write", 32'(cs_ce), 32'(0));
      chk("clk_ack_seen", 32'(seen), 32'(1));
      chk("clk_enb_at_ack", 32'(ack_ce), 32'(1));

      // All three requesting back-to-back reads from reset: round-robin order.
      @(negedge mclk);
      s_reset = 1'b1;
      @(negedge mclk);
      s_reset = 1'b0;
      last_rd = '0;
      lat = $urandom_range(0, 2);
      rem = '{2, 1, 1};
      lastg = 2;
      for (int j = 0; j < 3; j++) aa[j] = 3'($urandom_range(1, 7));
      for (int k = 0; k < 4; k++)
         for (int d = 1; d <= 3; d++) begin
            int j;
            j = (lastg + d) % 3;
            if (rem[j] > 0) begin
               rem[j]--;
               lastg = j;
               expect_txn(j, 1'b0, aa[j], 4'hF, 32'h0);
               break;
            end
         end
      for (int j = 0; j < 3; j++) drive(j, 1'b0, aa[j], 4'hF, 32'h0);
      left = '{2, 1, 1};
      guard = 0;
      while (left[0] + left[1] + left[2] > 0 && guard < 400) begin
         @(negedge mclk);
         guard++;
         for (int j = 0; j < 3; j++)
            if (req_ack[j] && left[j] > 0) begin
               left[j]--;
               if (left[j] == 0) req_cs[j] = 1'b0;
            end
      end
      chk("rr_all_done", 32'(left[0] + left[1] + left[2]), 32'(0));
      req_cs = '0;

      // Reset during the post-write gate window aborts without an ack.
      @(negedge mclk);
      lat = 0;
      wd = $urandom;
      drive(2, 1'b1, CLK_CTRL_ADDR, 4'b0100, wd);
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge mclk);
         if (reg_cs && reg_ack) seen = 1'b1;
      end
      chk("abort_write_seen", 32'(seen), 32'(1));
      model_write(CLK_CTRL_ADDR, 4'b0100, wd);
      repeat (3) @(negedge mclk);
      chk("abort_gate_low", 32'(clk_enb), 32'(0));
      s_reset = 1'b1;
      @(posedge mclk);
      #1;
      chk("abort_clk_enb", 32'(clk_enb), 32'(1));
      chk("abort_busy", 32'(sched_busy), 32'(0));
      chk("abort_req_ack", 32'(req_ack), 32'(0));
      @(negedge mclk);
      s_reset = 1'b0;
      req_cs = '0;
      last_rd = '0;
      repeat (20) @(negedge mclk);

      // Randomized single transactions, with periodic clock-control writes.
      for (int n = 0; n < 40; n++) begin
         @(negedge mclk);
         i  = $urandom_range(0, 2);
         wr = 1'($urandom_range(0, 1));
         a  = 3'($urandom_range(0, 7));
         be = 4'($urandom);
         wd = $urandom;
         if (n % 8 == 7) begin
            wr = 1'b1;
            a = CLK_CTRL_ADDR;
            be[CLK_CTRL_BE_BIT] = 1'b1;
         end
         lat = $urandom_range(0, 3);
         expect_txn(i, wr, a, be, wd);
         drive(i, wr, a, be, wd);
         wait_ack(i, 300, cyc);
      end

`ifdef WBH_SCHED_TMO_EN
      @(negedge mclk);
      ack_en = 1'b0;
      last_rd = TMO_RDATA;
      sb.push_back('{1, TMO_RDATA});
      drive(1, 1'b0, 3'd3, 4'hF, 32'h0);
      wait_ack(1, 200, cyc);
      chk("tmo_wait_long", 32'(cyc >= 64), 32'(1));
      chk("tmo_err_set", 32'(tmo_err), 32'(1));
      ack_en = 1'b1;
`else
      chk("tmo_err_tied", 32'(tmo_err), 32'(0));
`endif

      repeat (5) @(negedge mclk);
      chk("sb_empty", 32'(sb.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wbh_reg_sched.md
WBH_REG_SCHED -- requirements
Module: wbh_reg_sched

Interface
REQ-001 SHALL have parameter GATE_PRE, default 4, meaning mclk cycles with clk_enb low before a clock-control write.
REQ-002 SHALL have parameter GATE_POST, default 8, meaning mclk cycles with clk_enb low after the clock-control write acks.
REQ-003 SHALL have parameter TMO_CYC, default 64, meaning the ack timeout limit; used only under WBH_SCHED_TMO_EN.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports, clock and reset first:
- mclk  in  1  sole clock
- s_reset  in  1  synchronous active-high reset
REQ-005 SHALL have requester ports (index 0 host, 1 uart master, 2 strap/boot FSM):
- req_cs  in  3  per-requester request
- req_wr  in  3  1=write, 0=read
- req_addr  in  9  3 bits per requester, requester i at [3i+2:3i]
- req_wdata  in  96  32 bits per requester
- req_be  in  12  4 bits per requester
- req_ack  out  3  one-cycle completion pulse
- req_rdata  out  32  read data, shared; valid with req_ack
REQ-006 SHALL have register-bus ports:
- reg_cs  out  1  request
- reg_wr  out  1  write
- reg_addr  out  3  address
- reg_wdata  out  32  write data
- reg_be  out  4  byte enables
- reg_rdata  in  32  read data
- reg_ack  in  1  completion
REQ-007 SHALL have status ports:
- clk_enb  out  1  wishbone/cpu clock-gate enable
- sched_busy  out  1  high when the FSM is not in IDLE
- tmo_err  out  1  sticky timeout flag

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, GATE_PRE, CLK_WR, GATE_POST, DONE.
REQ-009 SHALL arbitrate in IDLE by round-robin: priority starts at the index after the last granted requester; after reset the last grant is treated as 2, so requester 0 wins first.
REQ-010 SHALL latch the winner's wr/addr/wdata/be at grant; requester inputs SHALL be ignored until that requester's req_ack.
REQ-011 SHALL classify a latched write with addr==0 and be[2]==1 as clock-switch: IDLE->GATE_PRE; every other request goes IDLE->ISSUE.
REQ-012 SHALL drive reg_cs high from ISSUE/CLK_WR until reg_ack is sampled high, then drop reg_cs the next cycle; reg_cs SHALL never be high for two consecutive transactions without an intervening low cycle.
REQ-013 SHALL drive clk_enb low for GATE_PRE cycles, then go to CLK_WR, which issues the write with clk_enb still low.
REQ-014 SHALL, after the CLK_WR ack, hold clk_enb low for GATE_POST further cycles, then raise clk_enb in DONE.
REQ-015 SHALL, in DONE, pulse req_ack[grant] for one cycle and set req_rdata to the captured reg_rdata (reads) or hold its previous value (writes); the FSM then returns to IDLE.
REQ-016 SHALL give a non-clock transaction a minimum latency of 4 cycles from req_cs sampled to req_ack with a 1-cycle reg_ack.
REQ-017 SHALL treat simultaneous requests under REQ-009; a request that drops before grant SHALL be lost without an ack.
REQ-018 SHALL use a gate counter wide enough for max(GATE_PRE,GATE_POST); a value of 0 skips that phase.

Reset
REQ-019 SHALL, on s_reset: state IDLE, reg_cs=0, reg_wr=0, reg_addr=0, reg_wdata=0, reg_be=0, req_ack=0, req_rdata=0, clk_enb=1, sched_busy=0, tmo_err=0.
REQ-020 SHALL, on s_reset mid-sequence, abort immediately: clk_enb=1 and no ack to the aborted requester.

Configuration
REQ-021 SHALL, with WBH_SCHED_TMO_EN defined, count WAIT_ACK/CLK_WR cycles; at TMO_CYC without reg_ack it SHALL drop reg_cs, set tmo_err, return req_rdata=32'hDEAD_BEEF, and proceed to DONE (clock path through GATE_POST).
REQ-022 SHALL, with WBH_SCHED_TMO_EN undefined, wait indefinitely for reg_ack and tie tmo_err to 0.

Structure
REQ-023 SHALL place the FSM state enum, CLK_CTRL_ADDR (3'd0), CLK_CTRL_BE_BIT (2) and TMO_RDATA in shared package wbh_sched_pkg.
REQ-024 SHALL implement the round-robin arbiter as sub-module wbh_rr_arb3 (3 requests, grant one-hot, last-grant update on accept).

Verification
REQ-025 SHALL cover: req1 read addr 2, reg_rdata=32'h1234_5678, 1-cycle ack -> req_ack[1] at cycle 4, req_rdata=32'h1234_5678, clk_enb stays 1.
REQ-026 SHALL cover: req0 write addr 0, be=4'b0100, wdata=32'h0055_0000 -> clk_enb low 4 cycles before reg_cs, low 8 cycles after reg_ack, then req_ack[0].
REQ-027 SHALL cover: req_cs=3'b111 held with back-to-back reads -> grant order 0,1,2,0; reg_cs low at least 1 cycle between transactions.
REQ-028 SHALL cover: s_reset asserted in GATE_POST -> next cycle clk_enb=1, state IDLE, no req_ack.
REQ-029 SHALL cover, with WBH_SCHED_TMO_EN defined: reg_ack held 0 -> after 64 cycles req_ack pulses, req_rdata=32'hDEAD_BEEF, tmo_err=1.
